// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
//   rx_state_t   - receiver FSM encoding (2-bit)
//   UART_DATA_W  - payload width of one frame
//   bit_period() - clock cycles per bit, P = freq / speed (truncating)
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    RECV_DATA = 2'd2,
    STOP_BIT  = 2'd3
  } rx_state_t;

  function automatic logic [31:0] bit_period(input logic [31:0] freq,
                                             input logic [31:0] speed);
    return freq / speed;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: brings the asynchronous RX pin into the clk_i domain.
//   clk_i   - system clock
//   rst_i   - synchronous active-high reset (all flops reset to idle level 1)
//   rx_i    - raw serial line
//   rx_s2_o - synchronised line level
//   fall_o  - high for one cycle when the synchronised line goes 1 -> 0
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  output logic rx_s2_o,
  output logic fall_o
);

  logic rx_s1_q, rx_s2_q, rx_s3_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= rx_i;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  assign rx_s2_o = rx_s2_q;
  // rx_s3 is only a history bit; a line that stays low never re-fires.
  assign fall_o  = ~rx_s2_q & rx_s3_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first, idle-high line.
//   clk_i       - system clock, all logic on rising edge
//   rst_i       - synchronous active-high reset
//   rx_i        - asynchronous serial line
//   data_o      - last correctly framed byte, held until the next good frame
//   valid_o     - one-cycle pulse, data_o updated this cycle
//   frame_err_o - one-cycle pulse, stop bit sampled low, data_o unchanged
//   busy_o      - receiver is not idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned FREQ_CLK = 100000000,
  parameter int unsigned RX_SPEED = 115200
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   rx_i,
  output logic [UART_DATA_W-1:0] data_o,
  output logic                   valid_o,
  output logic                   frame_err_o,
  output logic                   busy_o
);

  localparam logic [31:0] P = bit_period(FREQ_CLK, RX_SPEED);
  localparam logic [31:0] H = P >> 1;

  logic rx_s2, rx_fall;

  uart_rx_sync u_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .rx_i    (rx_i),
    .rx_s2_o (rx_s2),
    .fall_o  (rx_fall)
  );

  rx_state_t              state_q, state_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic [UART_DATA_W-1:0] data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   frame_err_q, frame_err_d;

  logic half_tick, full_tick;
  assign half_tick = (cnt_q == H - 32'd1);
  assign full_tick = (cnt_q == P - 32'd1);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (rx_fall) state_d = START_BIT;
      // A start bit that is high again at mid-period was a glitch.
      START_BIT: if (half_tick) state_d = rx_s2 ? IDLE : RECV_DATA;
      RECV_DATA: if (full_tick && bit_idx_q == 3'd7) state_d = STOP_BIT;
      // Leaving at mid-stop-bit leaves half a bit to catch the next start edge.
      STOP_BIT:  if (full_tick) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    cnt_d       = cnt_q + 32'd1;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;

    // The counter restarts on every state change and on every data sample.
    if (state_q == IDLE || state_d != state_q) cnt_d = '0;

    unique case (state_q)
      START_BIT: if (half_tick) bit_idx_d = '0;
      RECV_DATA: begin
        if (full_tick) begin
          cnt_d     = '0;
          shift_d   = {rx_s2, shift_q[UART_DATA_W-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      STOP_BIT: begin
        if (full_tick) begin
          if (rx_s2) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = frame_err_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx. A reduced system clock keeps frames short:
// 16 MHz / 115200 -> P = 138 cycles per bit, H = 69.
module tb_uart_rx;

  localparam int unsigned FCLK = 16000000;
  localparam int unsigned SPD  = 115200;
  localparam int P = 138;
  localparam int H = 69;
  localparam int STROBE_LAT = H + 2 + 9 * P + 1;  // negedge count from start-bit drive

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid, ferr, busy;

  uart_rx #(.FREQ_CLK(FCLK), .RX_SPEED(SPD)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_i        (rx),
    .data_o      (data),
    .valid_o     (valid),
    .frame_err_o (ferr),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       err;
    logic [7:0] data;
    int         at;    // expected cyc at the strobe, -1 = don't care
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_err = 0;
  logic [7:0] last_good = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every strobe pops one expected frame.
  logic last_busy = 1'b0;
  logic prev_strobe = 1'b0;
  always @(negedge clk) begin
    if (valid || ferr) begin
      exp_t e;
      chk("strobe_exclusive", {31'd0, valid & ferr}, 32'd0);
      chk("strobe_consecutive", {31'd0, prev_strobe}, 32'd0);
      chk("busy_falls_with_strobe", {30'd0, last_busy, busy}, 32'd2);
      if (q.size() == 0) begin
        chk("unexpected_strobe", {30'd0, valid, ferr}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("strobe_kind", {30'd0, valid, ferr}, e.err ? 32'd1 : 32'd2);
        chk("strobe_data", {24'd0, data}, {24'd0, e.data});
        if (e.at >= 0) chk("strobe_cycle", cyc, e.at);
      end
    end
    prev_strobe <= valid | ferr;
    last_busy   <= busy;
  end

  // Drives one frame starting at the current negedge. With push set, the
  // expected strobe is queued; on a bad stop bit data must keep last_good.
  // The line is left at the stop-bit level.
  task automatic send(input logic [7:0] b, input logic stop, input bit push);
    if (push) begin
      q.push_back('{err: ~stop, data: (stop ? b : last_good), at: cyc + STROBE_LAT});
      if (stop) last_good = b;
    end
    rx = 1'b0;
    repeat (P) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (P) @(negedge clk);
    end
    rx = stop;
    repeat (P) @(negedge clk);
  endtask

  int busy_cnt;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_data", {24'd0, data}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_ferr", {31'd0, ferr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // single frame with exact strobe timing
    send(8'h55, 1'b1, 1'b1);
    repeat (P) @(negedge clk);

    // back-to-back frames
    send(8'hA5, 1'b1, 1'b1);
    send(8'h3C, 1'b1, 1'b1);
    repeat (P) @(negedge clk);

    // framing error, then line held low: no retrigger
    send(8'hFF, 1'b0, 1'b1);
    repeat (20 * P) @(negedge clk);
    chk("held_low_busy", {31'd0, busy}, 32'd0);
    chk("held_low_data", {24'd0, data}, 32'h3C);
    rx = 1'b1;
    repeat (2 * P) @(negedge clk);
    send(8'h12, 1'b1, 1'b1);
    repeat (P) @(negedge clk);

    // short start glitch: busy exactly H cycles, no strobe
    rx = 1'b0;
    busy_cnt = 0;
    fork
      begin repeat (40) @(negedge clk); rx = 1'b1; end
      begin
        repeat (3 * P) @(negedge clk) if (busy) busy_cnt++;
      end
    join
    chk("glitch_busy_cycles", busy_cnt, H);
    chk("glitch_data", {24'd0, data}, 32'h12);

    // reset during bit 4 of 0x81. The synchroniser restarts at 1, so the
    // still-low line (bits 4..6) looks like a fresh start edge; the receiver
    // then frames bits 5,6,7,stop and idle ones as 0xFC well after the
    // aborted frame would have ended.
    q.push_back('{err: 1'b0, data: 8'hFC, at: -1});
    fork
      send(8'h81, 1'b1, 1'b0);
      begin
        repeat (5 * P + 10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("data_after_rst", {24'd0, data}, 32'd0);
        repeat (4 * P) @(negedge clk);
        chk("no_strobe_in_aborted_frame", q.size(), 1);
      end
    join
    repeat (7 * P) @(negedge clk);
    last_good = 8'hFC;
    send(8'h81, 1'b1, 1'b1);
    repeat (P) @(negedge clk);

    // transmitter loopback sequence
    send(8'h00, 1'b1, 1'b1);
    send(8'h01, 1'b1, 1'b1);
    send(8'h80, 1'b1, 1'b1);
    send(8'hFF, 1'b1, 1'b1);
    repeat (2 * P) @(negedge clk);

    chk("all_expected_strobes_seen", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
